// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Central hazard and sequencing controller for a 5-stage MIPS pipeline.
// It drives the stall (EN) and flush (CLR) controls of the F/D and D/E
// pipeline registers and generates the operand forwarding selects for the
// Decode and Execute stages. It also tracks the busy window of the
// multi-cycle mul/div unit and keeps a saturating stall-cycle counter.
//
// Ports
//   CLK, RST                     clock, asynchronous active-low reset
//   RsD, RtD                     Decode-stage source registers
//   RsE, RtE                     Execute-stage source registers
//   WriteRegE/M/W, RegWriteE/M/W destination registers and write enables in E/M/W
//   MemtoRegE, MemtoRegM         load instruction in E/M
//   BranchD, JumpD, PCSrcD       Decode-stage branch, jump and branch-taken
//   MDOpD                        Decode instruction uses the mul/div unit
//   MDStartE                     mul/div issued from Execute this cycle
//   StallF, StallD, FlushE       pipeline hazard stall (all the same signal)
//   FlushD                       squash the F/D register for a taken branch or jump
//   ForwardAD, ForwardBD         forward ALUOutM to the Decode comparator
//   ForwardAE, ForwardBE         Execute operand select: 00 RF, 10 ALUOutM, 01 ResultW
//   MDBusy                       mul/div in progress
//   StallCount                   saturating count of cycles with StallD=1
module hazard_control_unit #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MD_LATENCY     = 32,
  parameter int unsigned CNT_WIDTH      = 6,
  parameter int unsigned PERF_WIDTH     = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [REG_ADDR_WIDTH-1:0] RsD,
  input  logic [REG_ADDR_WIDTH-1:0] RtD,
  input  logic [REG_ADDR_WIDTH-1:0] RsE,
  input  logic [REG_ADDR_WIDTH-1:0] RtE,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegE,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegM,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegW,
  input  logic                      RegWriteE,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      MemtoRegE,
  input  logic                      MemtoRegM,
  input  logic                      BranchD,
  input  logic                      JumpD,
  input  logic                      PCSrcD,
  input  logic                      MDOpD,
  input  logic                      MDStartE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      ForwardAD,
  output logic                      ForwardBD,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      MDBusy,
  output logic [PERF_WIDTH-1:0]     StallCount
);

  localparam logic [CNT_WIDTH-1:0]  MD_LOAD   = CNT_WIDTH'(MD_LATENCY);
  localparam logic [CNT_WIDTH-1:0]  MD_ONE    = CNT_WIDTH'(1);
  localparam logic [PERF_WIDTH-1:0] PERF_ONE  = PERF_WIDTH'(1);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e             md_state_q, md_state_d;
  logic [CNT_WIDTH-1:0]  md_cnt_q, md_cnt_d;
  logic [PERF_WIDTH-1:0] stall_count_q, stall_count_d;

  logic lwstall;
  logic branchstall;
  logic mdstall;
  logic stall;

  // Register $0 is hard-wired to zero, so it never produces a dependency.
  function automatic logic reg_hit(input logic [REG_ADDR_WIDTH-1:0] src,
                                   input logic [REG_ADDR_WIDTH-1:0] dst,
                                   input logic                      wen);
    return wen && (src != '0) && (src == dst);
  endfunction

  // Execute-stage forwarding; the younger M-stage result wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reg_hit(RsE, WriteRegM, RegWriteM)) begin
      ForwardAE = 2'b10;
    end else if (reg_hit(RsE, WriteRegW, RegWriteW)) begin
      ForwardAE = 2'b01;
    end
    if (reg_hit(RtE, WriteRegM, RegWriteM)) begin
      ForwardBE = 2'b10;
    end else if (reg_hit(RtE, WriteRegW, RegWriteW)) begin
      ForwardBE = 2'b01;
    end
  end

  // Decode-stage comparator forwarding from ALUOutM.
  always_comb begin
    ForwardAD = reg_hit(RsD, WriteRegM, RegWriteM);
    ForwardBD = reg_hit(RtD, WriteRegM, RegWriteM);
  end

  // Hazard detection: load-use, branch operand not yet available, mul/div busy.
  always_comb begin
    lwstall     = MemtoRegE && (reg_hit(RsD, WriteRegE, 1'b1) ||
                                reg_hit(RtD, WriteRegE, 1'b1));
    branchstall = BranchD && (reg_hit(RsD, WriteRegE, RegWriteE) ||
                              reg_hit(RtD, WriteRegE, RegWriteE) ||
                              reg_hit(RsD, WriteRegM, MemtoRegM) ||
                              reg_hit(RtD, WriteRegM, MemtoRegM));
    mdstall     = MDOpD && MDBusy;
    stall       = lwstall || branchstall || mdstall;
  end

  // A stalled redirect is held back and re-evaluated once the stall clears.
  always_comb begin
    StallF = stall;
    StallD = stall;
    FlushE = stall;
    FlushD = (PCSrcD || JumpD) && !stall;
  end

  // Mul/div busy tracker; a reissue while busy reloads the full latency.
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (MDStartE) begin
          md_state_d = MD_BUSY;
          md_cnt_d   = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (MDStartE) begin
          md_cnt_d = MD_LOAD;
        end else if (md_cnt_q == MD_ONE) begin
          md_state_d = MD_IDLE;
          md_cnt_d   = '0;
        end else begin
          md_cnt_d = md_cnt_q - MD_ONE;
        end
      end
    endcase
  end

  always_comb begin
    MDBusy = (md_state_q == MD_BUSY);
  end

  // Stall-cycle counter, sticks at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + PERF_ONE;
    end
  end

  always_comb begin
    StallCount = stall_count_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      md_state_q    <= MD_IDLE;
      md_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      md_state_q    <= md_state_d;
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized and directed stimulus for hazard_control_unit, checked by a
// queue-based scoreboard against a cycle-numbered reference model.
module tb_hazard_control_unit;

  localparam int unsigned RW   = 5;
  localparam int unsigned MDL  = 4;
  localparam int unsigned PW   = 4;
  localparam int          PMAX = 15;

  typedef struct {
    logic          rst;
    logic [RW-1:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic          rwe, rwm, rww, mtre, mtrm;
    logic          branch, jump, pcsrc, mdop, mdstart;
  } stim_t;

  typedef struct packed {
    logic [1:0]    fae;
    logic [1:0]    fbe;
    logic          fad;
    logic          fbd;
    logic          stallf;
    logic          stalld;
    logic          flushe;
    logic          flushd;
    logic          busy;
    logic [PW-1:0] cnt;
  } exp_t;

  logic          CLK, RST;
  logic [RW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic          BranchD, JumpD, PCSrcD, MDOpD, MDStartE;
  logic          StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MDBusy;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [PW-1:0] StallCount;

  hazard_control_unit #(
    .REG_ADDR_WIDTH(RW),
    .MD_LATENCY    (MDL),
    .CNT_WIDTH     (6),
    .PERF_WIDTH    (PW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
    .MDOpD(MDOpD), .MDStartE(MDStartE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MDBusy(MDBusy), .StallCount(StallCount)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model state: cycle number, last busy cycle, stall count.
  int   cyc      = 0;
  int   busy_end = -1;
  int   cnt_m    = 0;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic bit hit(input logic [RW-1:0] src, input logic [RW-1:0] dst,
                             input logic wen);
    return (wen == 1'b1) && (src != 0) && (src == dst);
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit busy, lw, br, st;
    busy = (cyc <= busy_end);
    e.fae = hit(s.rse, s.wrm, s.rwm) ? 2'b10 : (hit(s.rse, s.wrw, s.rww) ? 2'b01 : 2'b00);
    e.fbe = hit(s.rte, s.wrm, s.rwm) ? 2'b10 : (hit(s.rte, s.wrw, s.rww) ? 2'b01 : 2'b00);
    e.fad = hit(s.rsd, s.wrm, s.rwm);
    e.fbd = hit(s.rtd, s.wrm, s.rwm);
    lw = s.mtre && (hit(s.rsd, s.wre, 1'b1) || hit(s.rtd, s.wre, 1'b1));
    br = s.branch && (hit(s.rsd, s.wre, s.rwe) || hit(s.rtd, s.wre, s.rwe) ||
                      hit(s.rsd, s.wrm, s.mtrm) || hit(s.rtd, s.wrm, s.mtrm));
    st = lw || br || (s.mdop && busy);
    e.stallf = st;
    e.stalld = st;
    e.flushe = st;
    e.flushd = (s.pcsrc || s.jump) && !st;
    e.busy   = busy;
    e.cnt    = PW'(cnt_m);
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1;
    s.rsd = '0; s.rtd = '0; s.rse = '0; s.rte = '0;
    s.wre = '0; s.wrm = '0; s.wrw = '0;
    s.rwe = 1'b0; s.rwm = 1'b0; s.rww = 1'b0; s.mtre = 1'b0; s.mtrm = 1'b0;
    s.branch = 1'b0; s.jump = 1'b0; s.pcsrc = 1'b0; s.mdop = 1'b0; s.mdstart = 1'b0;
    return s;
  endfunction

  // Drive one cycle, push its expected outputs, then advance the model.
  task automatic cycle(input stim_t s);
    exp_t e;
    @(negedge CLK);
    RST = s.rst; RsD = s.rsd; RtD = s.rtd; RsE = s.rse; RtE = s.rte;
    WriteRegE = s.wre; WriteRegM = s.wrm; WriteRegW = s.wrw;
    RegWriteE = s.rwe; RegWriteM = s.rwm; RegWriteW = s.rww;
    MemtoRegE = s.mtre; MemtoRegM = s.mtrm;
    BranchD = s.branch; JumpD = s.jump; PCSrcD = s.pcsrc;
    MDOpD = s.mdop; MDStartE = s.mdstart;
    if (!s.rst) begin
      busy_end = cyc - 1;
      cnt_m    = 0;
    end
    e = model(s);
    exp_q.push_back(e);
    @(posedge CLK);
    if (s.rst) begin
      cyc++;
      if (e.stalld) cnt_m = (cnt_m < PMAX) ? cnt_m + 1 : PMAX;
      if (s.mdstart) busy_end = cyc + int'(MDL) - 1;
    end
  endtask

  // Monitor: outputs are presented every cycle; compare away from the edge.
  always @(negedge CLK) begin
    exp_t e, a;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.fae = ForwardAE; a.fbe = ForwardBE; a.fad = ForwardAD; a.fbd = ForwardBD;
      a.stallf = StallF; a.stalld = StallD; a.flushe = FlushE; a.flushd = FlushD;
      a.busy = MDBusy; a.cnt = StallCount;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t act{fae,fbe,fad,fbd,sf,sd,fe,fd,busy,cnt}=%b_%b_%b%b_%b%b%b%b_%b_%0d req=%b_%b_%b%b_%b%b%b%b_%b_%0d",
                 $time, a.fae, a.fbe, a.fad, a.fbd, a.stallf, a.stalld, a.flushe, a.flushd,
                 a.busy, a.cnt, e.fae, e.fbe, e.fad, e.fbd, e.stallf, e.stalld, e.flushe,
                 e.flushd, e.busy, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    RST = 1'b0;
    RsD = '0; RtD = '0; RsE = '0; RtE = '0; WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; JumpD = 1'b0; PCSrcD = 1'b0; MDOpD = 1'b0; MDStartE = 1'b0;

    // Reset, then idle: everything zero.
    s = idle(); s.rst = 1'b0;
    cycle(s); cycle(s);
    cycle(idle()); cycle(idle());

    // Reset mid mul/div and with a nonzero stall count.
    s = idle(); s.mtre = 1'b1; s.wre = 5'd8; s.rtd = 5'd8; cycle(s); cycle(s);
    s = idle(); s.mdstart = 1'b1; cycle(s);
    cycle(idle());
    s = idle(); s.rst = 1'b0; cycle(s);
    cycle(idle()); cycle(idle());

    // Forwarding priority M over W, then W only, then $0.
    s = idle(); s.rse = 5'd5; s.wrm = 5'd5; s.wrw = 5'd5; s.rwm = 1'b1; s.rww = 1'b1;
    cycle(s);
    s.rwm = 1'b0; cycle(s);
    s.rse = 5'd0; cycle(s);
    s = idle(); s.rte = 5'd7; s.rtd = 5'd7; s.wrm = 5'd7; s.rwm = 1'b1; cycle(s);

    // Load-use, then WriteRegE=RtD=0.
    s = idle(); s.mtre = 1'b1; s.wre = 5'd8; s.rtd = 5'd8; cycle(s);
    cycle(idle());
    s = idle(); s.mtre = 1'b1; cycle(s);

    // Branch stall suppresses the flush, then flush once the hazard is gone.
    s = idle(); s.branch = 1'b1; s.rsd = 5'd3; s.rwe = 1'b1; s.wre = 5'd3; s.pcsrc = 1'b1;
    cycle(s);
    s.rwe = 1'b0; s.wre = 5'd0; cycle(s);
    s = idle(); s.branch = 1'b1; s.rtd = 5'd9; s.mtrm = 1'b1; s.wrm = 5'd9; s.jump = 1'b1;
    cycle(s);
    cycle(idle());

    // Mul/div window with MDOpD held, then a reload two cycles in.
    s = idle(); s.mdstart = 1'b1; cycle(s);
    s = idle(); s.mdop = 1'b1;
    for (int i = 0; i < 6; i++) cycle(s);
    s = idle(); s.mdstart = 1'b1; cycle(s);
    cycle(idle());
    s = idle(); s.mdstart = 1'b1; cycle(s);
    s = idle(); s.mdop = 1'b1;
    for (int i = 0; i < 6; i++) cycle(s);

    // Stall counter saturation.
    s = idle(); s.mtre = 1'b1; s.wre = 5'd4; s.rsd = 5'd4;
    for (int i = 0; i < 20; i++) cycle(s);
    s = idle(); s.rst = 1'b0; cycle(s);

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      s.rst     = ($urandom_range(0, 59) != 0);
      s.rsd     = RW'($urandom_range(0, 3));
      s.rtd     = RW'($urandom_range(0, 3));
      s.rse     = RW'($urandom_range(0, 3));
      s.rte     = RW'($urandom_range(0, 3));
      s.wre     = RW'($urandom_range(0, 3));
      s.wrm     = RW'($urandom_range(0, 3));
      s.wrw     = RW'($urandom_range(0, 3));
      s.rwe     = 1'($urandom_range(0, 1));
      s.rwm     = 1'($urandom_range(0, 1));
      s.rww     = 1'($urandom_range(0, 1));
      s.mtre    = ($urandom_range(0, 3) == 0);
      s.mtrm    = ($urandom_range(0, 3) == 0);
      s.branch  = ($urandom_range(0, 2) == 0);
      s.jump    = ($urandom_range(0, 5) == 0);
      s.pcsrc   = ($urandom_range(0, 3) == 0);
      s.mdop    = ($urandom_range(0, 2) == 0);
      s.mdstart = ($urandom_range(0, 7) == 0);
      cycle(s);
    end
    cycle(idle());

    @(negedge CLK);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
